// File: rtl/ddr3_pkg.sv
// Types and sizes shared by the DDR3 read-capture stage and the command FSM.
package ddr3_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CL = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } rd_cap_state_t;

  localparam int DDR3_BL    = 8;
  localparam int DDR3_DQ_W  = 8;
  localparam int DDR3_RD_W  = 64;
  localparam int DDR3_CNT_W = 4;
  localparam int DDR3_BEAT_W = 3;

endpackage

// File: rtl/ddr3_rd_capture.sv
// DDR3 read-data capture: waits CAS latency after a READ issue, collects BL
// DQS-qualified beats into one word and presents it to the CPU side.
module ddr3_rd_capture
  import ddr3_pkg::*;
#(
  parameter int CL  = 5,
  parameter int BL  = DDR3_BL,
  parameter int DW  = DDR3_DQ_W,
  parameter int TMO = 4
) (
  input  logic                 CPU_CLK,
  input  logic                 RESET,
  input  logic                 RD_ISSUE,
  input  logic [DW-1:0]        DQ_IN,
  input  logic                 DQS_IN,
  output logic                 RD_DATA_RDY,
  output logic                 RD_DATA_VALID,
  output logic [DDR3_RD_W-1:0] RD_DATA,
  output logic                 RD_ERR,
  output rd_cap_state_t        dbg_state_o
);

  if (BL * DW != DDR3_RD_W) begin : g_bad_width
    $error("ddr3_rd_capture: BL*DW must equal 64");
  end
  if (CL < 1 || CL > 15) begin : g_bad_cl
    $error("ddr3_rd_capture: CL must be in 1..15");
  end
  if (TMO < 1 || TMO > 15) begin : g_bad_tmo
    $error("ddr3_rd_capture: TMO must be in 1..15");
  end

  localparam logic [DDR3_CNT_W-1:0]  LAT_LOAD  = DDR3_CNT_W'(CL - 1);
  localparam logic [DDR3_CNT_W-1:0]  TMO_LIMIT = DDR3_CNT_W'(TMO);
  localparam logic [DDR3_BEAT_W-1:0] LAST_BEAT = DDR3_BEAT_W'(BL - 1);

  rd_cap_state_t              state_q, state_d;
  logic [DDR3_CNT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [DDR3_CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [DDR3_BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [DDR3_RD_W-1:0]       shift_q, shift_d;
  logic [DDR3_RD_W-1:0]       rd_data_q, rd_data_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;

  // CPU-side handshake: RD_DATA_RDY high means an RD_ISSUE sampled on the next
  // edge starts a burst; RD_DATA_VALID is a one-cycle pulse with no back-pressure,
  // RD_DATA is stable from that pulse until the next completed burst.
  always_ff @(posedge CPU_CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      beat_cnt_q <= '0;
      shift_q    <= '0;
      rd_data_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    beat_cnt_d = beat_cnt_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (RD_ISSUE) begin
          lat_cnt_d  = LAT_LOAD;
          beat_cnt_d = '0;
          tmo_cnt_d  = '0;
          // CL=1 puts the first sampling edge right after the issue edge.
          state_d    = (CL == 1) ? CAPTURE : WAIT_CL;
        end
      end

      WAIT_CL: begin
        err_d     = RD_ISSUE;
        lat_cnt_d = lat_cnt_q - 1'b1;
        // Leave one cycle early so the first sample lands exactly CL edges after issue.
        if (lat_cnt_q == DDR3_CNT_W'(1)) begin
          state_d    = CAPTURE;
          beat_cnt_d = '0;
          tmo_cnt_d  = '0;
        end
      end

      CAPTURE: begin
        err_d = RD_ISSUE;
        if (DQS_IN) begin
          shift_d[int'(beat_cnt_q)*DW +: DW] = DQ_IN;
          tmo_cnt_d  = '0;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            rd_data_d = shift_d;
            valid_d   = 1'b1;
            state_d   = DONE;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          if (tmo_cnt_d == TMO_LIMIT) begin
            err_d     = 1'b1;
            tmo_cnt_d = '0;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign RD_DATA_RDY   = (state_q == IDLE) || (state_q == DONE);
  assign RD_DATA_VALID = valid_q;
  assign RD_DATA       = rd_data_q;
  assign RD_ERR        = err_q;
  assign dbg_state_o   = state_q;

endmodule
